// File: rtl/exe_unit_seq.sv
// Handshaked execute unit: single-cycle ALU ops and shifts, plus an iterative
// shift-add multiply, with NZCV status held on a valid/ready output register.
module exe_unit_seq #(
   parameter int N      = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         carry_in,
   input  logic [3:0]   exe_cmd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [3:0]   status,
   output logic         busy
);

   localparam int CW = $clog2(N + 1);

   localparam logic [3:0] CmdMov = 4'b0001;
   localparam logic [3:0] CmdAdd = 4'b0010;
   localparam logic [3:0] CmdAdc = 4'b0011;
   localparam logic [3:0] CmdSub = 4'b0100;
   localparam logic [3:0] CmdSbc = 4'b0101;
   localparam logic [3:0] CmdAnd = 4'b0110;
   localparam logic [3:0] CmdOrr = 4'b0111;
   localparam logic [3:0] CmdEor = 4'b1000;
   localparam logic [3:0] CmdMvn = 4'b1001;
   localparam logic [3:0] CmdMul = 4'b1010;
   localparam logic [3:0] CmdLsl = 4'b1011;
   localparam logic [3:0] CmdLsr = 4'b1100;
   localparam logic [3:0] CmdAsr = 4'b1101;

   typedef enum logic {IDLE, MUL} stateT;

   stateT         state, stateNext;
   logic [CW-1:0] cntP0;
   logic [N-1:0]  accP0, aShP0, bShP0;
   logic [N-1:0]  accNext;
   logic          accept, isMul, loadMul, complete;
   logic [N-1:0]  doneRes;
   logic [3:0]    doneStat;

   // Single-cycle datapath; returns {N, Z, C, V, result}.
   function automatic logic [N+3:0] aluOp(input logic [3:0] cmd, input logic [N-1:0] opA,
                                          input logic [N-1:0] opB, input logic cIn);
      logic [N:0]        wide;
      logic signed [N:0] asrW;
      logic [N-1:0]      res;
      logic              c, v;
      logic [7:0]        amt;
      wide = '0;
      asrW = '0;
      res  = '0;
      c    = 1'b0;
      v    = 1'b0;
      amt  = opB[7:0];
      case (cmd)
         CmdMov: res = opB;
         CmdMvn: res = ~opB;
         CmdAdd, CmdAdc: begin
            wide = {1'b0, opA} + {1'b0, opB} + {{N{1'b0}}, (cmd == CmdAdc) & cIn};
            res  = wide[N-1:0];
            c    = wide[N];
            v    = (opA[N-1] == opB[N-1]) && (res[N-1] != opA[N-1]);
         end
         CmdSub, CmdSbc: begin
            wide = {1'b0, opA} - {1'b0, opB} - {{N{1'b0}}, (cmd == CmdSbc) & ~cIn};
            res  = wide[N-1:0];
            c    = wide[N];
            v    = (opA[N-1] != opB[N-1]) && (res[N-1] != opA[N-1]);
         end
         CmdAnd: res = opA & opB;
         CmdOrr: res = opA | opB;
         CmdEor: res = opA ^ opB;
         // A guard bit beside the operand captures the last bit shifted out;
         // oversized amounts fall out naturally as zero or sign fill.
         CmdLsl: begin
            if (amt == 8'd0) begin
               res = opA;
               c   = cIn;
            end else begin
               wide = {1'b0, opA} << amt;
               res  = wide[N-1:0];
               c    = wide[N];
            end
         end
         CmdLsr: begin
            if (amt == 8'd0) begin
               res = opA;
               c   = cIn;
            end else begin
               wide = {opA, 1'b0} >> amt;
               res  = wide[N:1];
               c    = wide[0];
            end
         end
         CmdAsr: begin
            if (amt == 8'd0) begin
               res = opA;
               c   = cIn;
            end else begin
               asrW = $signed({opA, 1'b0}) >>> amt;
               res  = asrW[N:1];
               c    = asrW[0];
            end
         end
         default: res = '0;
      endcase
      return {res[N-1], (res == '0), c, v, res};
   endfunction

   always_comb begin
      stateNext = state;
      loadMul   = 1'b0;
      complete  = 1'b0;
      doneRes   = '0;
      doneStat  = '0;
      in_ready  = (state == IDLE) && (!out_valid || out_ready);
      accept    = in_valid && in_ready;
      isMul     = MUL_EN && (exe_cmd == CmdMul);
      accNext   = accP0 + (bShP0[0] ? aShP0 : '0);
      case (state)
         IDLE: begin
            if (accept) begin
               if (isMul) begin
                  stateNext = MUL;
                  loadMul   = 1'b1;
               end else begin
                  complete            = 1'b1;
                  {doneStat, doneRes} = aluOp(exe_cmd, a, b, carry_in);
               end
            end
         end
         MUL: begin
            if (cntP0 == CW'(2)) begin
               stateNext = IDLE;
               complete  = 1'b1;
               doneRes   = accNext;
               doneStat  = {accNext[N-1], (accNext == '0), 2'b00};
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign busy = (state == MUL);

   // Multiply iteration registers; the accept edge already folds in bit 0 of b
   // so N partial products fit in the N-cycle latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cntP0 <= '0;
         accP0 <= '0;
         aShP0 <= '0;
         bShP0 <= '0;
      end else begin
         state <= stateNext;
         if (loadMul) begin
            accP0 <= b[0] ? a : '0;
            aShP0 <= a << 1;
            bShP0 <= b >> 1;
            cntP0 <= CW'(N);
         end else if (state == MUL) begin
            accP0 <= accNext;
            aShP0 <= aShP0 << 1;
            bShP0 <= bShP0 >> 1;
            cntP0 <= cntP0 - CW'(1);
         end
      end
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         status    <= '0;
      end else if (complete) begin
         out_valid <= 1'b1;
         result    <= doneRes;
         status    <= doneStat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exe_unit_seq.sv
// Scoreboard bench for exe_unit_seq: a 32-bit unit with MUL and an 8-bit unit
// without it, sharing clock and reset.
module tb_exe_unit_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rstN;
   logic        inValid, inReady, carryIn, outValid, outReady, busy;
   logic [31:0] a, b, result;
   logic [3:0]  cmd, status;

   logic        inValid8, inReady8, carryIn8, outValid8, outReady8, busy8;
   logic [7:0]  a8, b8, result8;
   logic [3:0]  cmd8, status8;

   exe_unit_seq #(.N(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
      .a(a), .b(b), .carry_in(carryIn), .exe_cmd(cmd),
      .out_valid(outValid), .out_ready(outReady), .result(result),
      .status(status), .busy(busy)
   );

   exe_unit_seq #(.N(8), .MUL_EN(1'b0)) dut8 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid8), .in_ready(inReady8),
      .a(a8), .b(b8), .carry_in(carryIn8), .exe_cmd(cmd8),
      .out_valid(outValid8), .out_ready(outReady8), .result(result8),
      .status(status8), .busy(busy8)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  st;
      int          edgeNo;
   } expT;

   expT scq[$];

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model: wide arithmetic and bit-at-a-time shifts.
   function automatic logic [35:0] model32(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci);
      logic [63:0] w;
      logic [31:0] r;
      logic        cf, vf;
      int          amt;
      w = '0; r = '0; cf = 1'b0; vf = 1'b0; amt = int'(y[7:0]);
      case (c)
         4'd1: r = y;
         4'd9: r = ~y;
         4'd2, 4'd3: begin
            w  = 64'(x) + 64'(y) + ((c == 4'd3 && ci) ? 64'd1 : 64'd0);
            r  = w[31:0]; cf = w[32];
            vf = (x[31] == y[31]) && (r[31] != x[31]);
         end
         4'd4, 4'd5: begin
            w  = 64'(x) - 64'(y) - ((c == 4'd5 && !ci) ? 64'd1 : 64'd0);
            r  = w[31:0]; cf = w[32];
            vf = (x[31] != y[31]) && (r[31] != x[31]);
         end
         4'd6: r = x & y;
         4'd7: r = x | y;
         4'd8: r = x ^ y;
         4'd10: begin w = 64'(x) * 64'(y); r = w[31:0]; end
         4'd11, 4'd12, 4'd13: begin
            r = x; cf = ci;
            for (int i = 0; i < amt; i++) begin
               if (c == 4'd11) begin cf = r[31]; r = {r[30:0], 1'b0}; end
               else if (c == 4'd12) begin cf = r[0]; r = {1'b0, r[31:1]}; end
               else begin cf = r[0]; r = {r[31], r[31:1]}; end
            end
         end
         default: r = '0;
      endcase
      return {r[31], (r == 32'd0), cf, vf, r};
   endfunction

   task automatic pushExp(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          input logic ci);
      expT         e;
      logic [35:0] m;
      m        = model32(c, x, y, ci);
      e.res    = m[31:0];
      e.st     = m[35:32];
      e.edgeNo = cyc + 1 + ((c == 4'd10) ? 31 : 0);
      scq.push_back(e);
   endtask

   task automatic sendOp(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic ci);
      int guard;
      @(negedge clk);
      inValid = 1'b1; cmd = c; a = x; b = y; carryIn = ci;
      #1;
      guard = 0;
      while (!inReady && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!inReady) begin
         checkEq("acceptTimeout", 0, 1);
         inValid = 1'b0;
      end else begin
         pushExp(c, x, y, ci);
         @(posedge clk);
      end
   endtask

   task automatic idleCycles(input int n);
      @(negedge clk);
      inValid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Operands are scrambled while the multiply runs; they must be ignored.
   task automatic mulWatch();
      int seen;
      seen = 0;
      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
         #1;
         if (busy && !inReady) seen++;
      end
      checkEq("mulBusyWindow", seen, 31);
      @(negedge clk);
      inValid = 1'b0;
      #1;
      checkEq("mulDoneBusy", busy, 0);
   endtask

   expT         mon;
   logic        prevValid = 1'b0;
   logic [31:0] prevRes   = '0;
   logic [3:0]  prevSt    = '0;

   always @(posedge clk) begin
      #1;
      if (!rstN) begin
         prevValid = 1'b0;
      end else begin
         if (outValid && (!prevValid || outReady)) begin
            if (scq.size() == 0) begin
               checkEq("spuriousResult", result, 0);
            end else begin
               mon = scq.pop_front();
               checkEq("result", result, mon.res);
               checkEq("status", status, mon.st);
               checkEq("latency", cyc, mon.edgeNo);
            end
         end else if (prevValid && !outReady) begin
            checkEq("holdValid", outValid, 1);
            checkEq("holdResult", result, prevRes);
            checkEq("holdStatus", status, prevSt);
         end
         prevValid = outValid;
         prevRes   = result;
         prevSt    = status;
      end
   end

   initial begin
      #500000;
      checkEq("watchdog", 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rstN = 1'b0;
      inValid = 1'b0; outReady = 1'b1; cmd = '0; a = '0; b = '0; carryIn = 1'b0;
      inValid8 = 1'b0; outReady8 = 1'b1; cmd8 = '0; a8 = '0; b8 = '0; carryIn8 = 1'b0;
      #12;
      checkEq("rstOutValid", outValid, 0);
      checkEq("rstResult", result, 0);
      checkEq("rstStatus", status, 0);
      checkEq("rstBusy", busy, 0);
      checkEq("rstOutValid8", outValid8, 0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checkEq("readyAfterReset", inReady, 1);

      // 8-bit unit without multiplier
      @(negedge clk);
      inValid8 = 1'b1; cmd8 = 4'b1010; a8 = 8'd3; b8 = 8'd5;
      #1;
      checkEq("n8Ready", inReady8, 1);
      @(posedge clk);
      #1;
      checkEq("n8UndefValid", outValid8, 1);
      checkEq("n8UndefResult", result8, 0);
      checkEq("n8UndefStatus", status8, 4'b0100);
      checkEq("n8UndefBusy", busy8, 0);
      @(negedge clk);
      cmd8 = 4'b0010; a8 = 8'hFF; b8 = 8'h01;
      @(posedge clk);
      #1;
      checkEq("n8AddResult", result8, 8'h00);
      checkEq("n8AddStatus", status8, 4'b0110);
      @(negedge clk);
      cmd8 = 4'b0100; a8 = 8'h80; b8 = 8'h01;
      @(posedge clk);
      #1;
      checkEq("n8SubResult", result8, 8'h7F);
      checkEq("n8SubStatus", status8, 4'b0001);
      @(negedge clk);
      inValid8 = 1'b0;

      // Back-to-back ALU ops
      sendOp(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0);
      sendOp(4'b0100, 32'd0, 32'd1, 1'b0);
      sendOp(4'b0101, 32'd5, 32'd3, 1'b0);
      sendOp(4'b1000, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
      sendOp(4'b0011, 32'hFFFF_FFFF, 32'd0, 1'b1);
      sendOp(4'b0001, 32'd9, 32'h8000_0000, 1'b0);
      sendOp(4'b1001, 32'd9, 32'h0000_00FF, 1'b0);
      sendOp(4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
      sendOp(4'b0111, 32'hF000_0000, 32'h0000_000F, 1'b0);
      sendOp(4'b0000, 32'h1234, 32'h5678, 1'b1);
      sendOp(4'b1110, 32'h1234, 32'h5678, 1'b1);
      sendOp(4'b1111, 32'h1234, 32'h5678, 1'b1);
      idleCycles(2);

      // Shifts
      sendOp(4'b1011, 32'h8000_0001, 32'd1, 1'b0);
      sendOp(4'b1100, 32'h8000_0001, 32'd0, 1'b1);
      sendOp(4'b1101, 32'h8000_0001, 32'd40, 1'b0);
      sendOp(4'b1100, 32'h8000_0001, 32'd33, 1'b1);
      sendOp(4'b1011, 32'h8000_0001, 32'd32, 1'b0);
      sendOp(4'b1101, 32'h4000_0003, 32'd2, 1'b0);
      idleCycles(2);

      // Multiply
      sendOp(4'b1010, 32'h0001_0000, 32'h0001_0001, 1'b0);
      mulWatch();
      sendOp(4'b1010, 32'd12345, 32'd678, 1'b0);
      mulWatch();
      sendOp(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b0);
      mulWatch();
      sendOp(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      mulWatch();
      idleCycles(2);

      // Back-pressure, then release with the next op held on the input
      sendOp(4'b0010, 32'd100, 32'd23, 1'b0);
      @(negedge clk);
      outReady = 1'b0;
      inValid = 1'b1; cmd = 4'b0100; a = 32'd50; b = 32'd8; carryIn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkEq("bpInReady", inReady, 0);
         checkEq("bpOutValid", outValid, 1);
         @(negedge clk);
      end
      outReady = 1'b1;
      #1;
      checkEq("bpReleaseReady", inReady, 1);
      pushExp(4'b0100, 32'd50, 32'd8, 1'b0);
      @(posedge clk);
      idleCycles(2);

      // Reset in the middle of a multiply
      sendOp(4'b1010, 32'd7, 32'd6, 1'b0);
      @(negedge clk);
      inValid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      scq.delete();
      checkEq("abortOutValid", outValid, 0);
      checkEq("abortBusy", busy, 0);
      checkEq("abortResult", result, 0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checkEq("abortReady", inReady, 1);
      repeat (40) @(negedge clk);
      checkEq("abortNoStale", outValid, 0);

      sendOp(4'b0010, 32'd1, 32'd2, 1'b0);
      idleCycles(3);
      checkEq("queueDrained", scq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
